// File: rtl/io_po_pkg.sv
// Shared types and line levels for the io_po serial arbiter.
package io_po_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/io_po_rr_arbiter.sv
// Round-robin pick: first valid index at or above ptr_i, wrapping.
// Purely combinational.
module io_po_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    // Walk offsets from largest to smallest so the nearest valid index wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (valid_i[cand]) begin
                idx_o = ID_W'(cand);
                any_o = 1'b1;
            end
        end
        grant_o[idx_o] = any_o;
    end

endmodule

// File: rtl/io_po_serial_arbiter.sv
// Shares one io_po_core output pad between NUM_REQ requesters.
// Round-robin grant in IDLE, then a framed serial word: start, data LSB-first,
// optional parity, stop. Each bit lasts CLKS_PER_BIT clocks; the line is registered,
// so it trails the state by one clock.
// Build option: define IO_PO_PARITY_EN to insert an even-parity bit before stop.
module io_po_serial_arbiter
    import io_po_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       io_po_core_outpad,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id,
    output logic                       frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               outpad_q;
    logic               line;
    logic               bit_end;
`ifdef IO_PO_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [NUM_REQ-1:0] win_grant;
    logic [ID_W-1:0]    win_idx;
    logic               win_any;

    io_po_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    assign bit_end = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state, grant capture, bit timing and the line level of the current state.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        req_ready  = '0;
        frame_done = 1'b0;
        line       = IDLE_LVL;
`ifdef IO_PO_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != IDLE) begin
            bit_cnt_d = bit_end ? '0 : CNT_W'(bit_cnt_q + 1'b1);
        end
        case (state_q)
            IDLE: begin
                line      = IDLE_LVL;
                bit_cnt_d = '0;
                idx_d     = '0;
                // Ready is masked during reset so a held request is never acknowledged.
                if (win_any && !reset) begin
                    req_ready  = win_grant;
                    shift_d    = req_data[int'(win_idx)*WIDTH +: WIDTH];
                    grant_id_d = win_idx;
                    rr_ptr_d   = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win_idx + 1'b1);
                    state_d    = START;
`ifdef IO_PO_PARITY_EN
                    par_d      = ^req_data[int'(win_idx)*WIDTH +: WIDTH];
`endif
                end
            end
            START: begin
                line = START_LVL;
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                line = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = IDX_W'(idx_q + 1'b1);
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        idx_d = '0;
`ifdef IO_PO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef IO_PO_PARITY_EN
            PARITY: begin
                line = par_q;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                line = STOP_LVL;
                if (bit_end) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame and parks the line high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            outpad_q   <= IDLE_LVL;
`ifdef IO_PO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            outpad_q   <= line;
`ifdef IO_PO_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign io_po_core_outpad = outpad_q;
    assign busy              = (state_q != IDLE);
    assign grant_id          = grant_id_q;

endmodule

// File: tb/tb_io_po_serial_arbiter.sv
// Directed bench for io_po_serial_arbiter (default parameters).
module tb_io_po_serial_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int CPB     = 4;
    localparam int ID_W    = 2;
`ifdef IO_PO_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (2 + WIDTH + P) * CPB;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     outpad;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;
    logic                     frame_done;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] words [NUM_REQ];

    typedef struct {
        logic [NUM_REQ-1:0] valid;
        int                 exp_w;
    } vec_t;

    vec_t vecs [10];

    io_po_serial_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WIDTH        (WIDTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .io_po_core_outpad (outpad),
        .busy              (busy),
        .grant_id          (grant_id),
        .frame_done        (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line n cycles after the ready cycle: one clock of idle level,
    // then start, data LSB-first, optional parity, stop, each CPB clocks.
    function automatic logic exp_line(input logic [WIDTH-1:0] word, input int n);
        int j;
        if (n < 2) return 1'b1;
        j = (n - 2) / CPB;
        if (j == 0) return 1'b0;
        if (j <= WIDTH) return word[j-1];
        if (P == 1 && j == WIDTH + 1) return ^word;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [NUM_REQ-1:0] v, input int w);
        logic [WIDTH-1:0] word;
        bit got;
        word = words[w];
        got  = 1'b0;
        @(negedge clk);
        req_valid = v;
        #1;
        for (int k = 0; k < 200; k++) begin
            if (req_ready != '0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        check("ready_seen", 32'(got), 32'd1);
        if (!got) return;
        check("ready_onehot", 32'(req_ready), 32'(1 << w));
        for (int n = 1; n <= FRAME + 2; n++) begin
            @(negedge clk);
            #1;
            if (n == 1) begin
                check("ready_single", 32'(req_ready), 32'd0);
                check("grant_id", 32'(grant_id), 32'(w));
                req_valid = '0;
            end
            check("outpad", 32'(outpad), 32'(exp_line(word, n)));
            check("frame_done", 32'(frame_done), 32'(n == FRAME));
            check("busy", 32'(busy), 32'(n >= 1 && n <= FRAME));
        end
    endtask

    initial begin
        int k;
        int last;
        bit pend;

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h0F;
        words[3] = 8'hE1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];

        vecs[0] = '{4'b0001, 0};
        vecs[1] = '{4'b1111, 1};
        vecs[2] = '{4'b0001, 0};
        vecs[3] = '{4'b1010, 1};
        vecs[4] = '{4'b1001, 3};
        vecs[5] = '{4'b1010, 1};
        vecs[6] = '{4'b0100, 2};
        vecs[7] = '{4'b1010, 3};
        vecs[8] = '{4'b1010, 1};
        vecs[9] = '{4'b1001, 3};

        // Reset values, with requests held to show ready stays low in reset.
        reset     = 1'b1;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outpad", 32'(outpad), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;

        // Table: arbitration order carries rr_ptr from one vector to the next.
        for (int i = 0; i < 10; i++) run_frame(vecs[i].valid, vecs[i].exp_w);

        // All requesters valid continuously from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 4'b1111;
        k = 0;
        last = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 5 * (FRAME + 1) + 20 && k < 5; cyc++) begin
            #1;
            if (req_ready != '0) begin
                check("cont_ready", 32'(req_ready), 32'(1 << (k % 4)));
                if (k > 0) check("cont_gap", 32'(cyc - last), 32'(FRAME + 1));
                last = cyc;
                k++;
                pend = 1'b1;
            end else if (pend) begin
                check("cont_grant_id", 32'(grant_id), 32'((k - 1) % 4));
                pend = 1'b0;
            end
            @(negedge clk);
        end
        check("cont_grants", 32'(k), 32'd5);
        req_valid = '0;
        repeat (FRAME + 4) @(negedge clk);

        // Reset during data bit 3 of a frame granted to req 2.
        req_valid = 4'b0100;
        #1;
        check("mid_ready", 32'(req_ready), 32'b0100);
        repeat (18) @(negedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        reset     = 1'b1;
        req_valid = 4'b0010;
        #1;
        check("mid_outpad", 32'(outpad), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready_in_rst", 32'(req_ready), 32'd0);
        check("mid_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (FRAME + 4) @(negedge clk);

        // Quiet line with no requests.
        for (int c = 0; c < 100; c++) begin
            #1;
            check("idle_quiet", 32'({outpad, busy, req_ready, frame_done}), 32'({1'b1, 1'b0, 4'b0000, 1'b0}));
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
